// File: rtl/serial_add_ctrl.sv
// Multi-cycle adder: one CHUNK-bit full-adder slice is sequenced over WIDTH/CHUNK cycles,
// with valid/ready handshakes on both sides. Optional subtract mode via SERIAL_ADD_SUB_EN.
module serial_add_ctrl #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = $clog2(NCHUNK + 1);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
    // valid never depends on ready; ready/valid are decoded from the state register only.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH:0]   sum_q, sum_d;

    logic             sub_in;
    logic [CHUNK-1:0] slice_a, slice_b, slice_s;
    logic             slice_co;
    logic             rc;

`ifdef SERIAL_ADD_SUB_EN
    assign sub_in = sub;
`else
    assign sub_in = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = S_RUN;
            S_RUN:   if (idx_q == LAST_IDX) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        busy      = (state_q == S_RUN) || (state_q == S_DONE);
        out_valid = (state_q == S_DONE);
        sum       = sum_q;
    end

    // Select the active chunk of each operand register
    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (idx_q == IDXW'(k)) begin
                slice_a = a_q[k*CHUNK +: CHUNK];
                slice_b = b_q[k*CHUNK +: CHUNK];
            end
        end
    end

    // Ripple slice of full adders, fed by the registered inter-chunk carry
    always_comb begin
        rc      = carry_q;
        slice_s = '0;
        for (int i = 0; i < CHUNK; i++) begin
            slice_s[i] = slice_a[i] ^ slice_b[i] ^ rc;
            rc         = (slice_a[i] & slice_b[i]) | (rc & (slice_a[i] ^ slice_b[i]));
        end
        slice_co = rc;
    end

    // Datapath register updates
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    // Subtraction is a + ~b + 1: invert b once at capture, seed carry with 1.
                    b_d     = sub_in ? ~b : b;
                    carry_d = sub_in;
                    idx_d   = '0;
                end
            end
            S_RUN: begin
                for (int k = 0; k < NCHUNK; k++) begin
                    if (idx_q == IDXW'(k)) begin
                        sum_d[k*CHUNK +: CHUNK] = slice_s;
                    end
                end
                carry_d = slice_co;
                idx_d   = idx_q + IDXW'(1);
                if (idx_q == LAST_IDX) begin
                    sum_d[WIDTH] = slice_co;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed + random bench for serial_add_ctrl with a scoreboard of expected sums.
module tb_serial_add_ctrl;

    localparam int WIDTH  = 16;
    localparam int CHUNK  = 4;
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int MAXW   = 40;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub_s;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   sum;
    logic             busy;

    logic [WIDTH:0]   exp_q[$];
    logic [WIDTH:0]   e_v;
    int               n_cmp = 0;
    int               n_err = 0;
    logic             seen;

    serial_add_ctrl #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
`ifdef SERIAL_ADD_SUB_EN
        .sub      (sub_s),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .busy     (busy)
    );

    // Clock
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic s);
        logic [WIDTH:0] r;
        if (s) r = {1'b0, x} + {1'b0, ~y} + (WIDTH+1)'(1);
        else   r = {1'b0, x} + {1'b0, y};
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one operand handshake and push its expected result
    task automatic start(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s);
        check("start_in_ready", 32'(in_ready), 1);
        a = x;
        b = y;
`ifdef SERIAL_ADD_SUB_EN
        sub_s = s;
`endif
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        exp_q.push_back(model(x, y, s));
        check("run_busy", 32'(busy), 1);
        check("run_in_ready", 32'(in_ready), 0);
    endtask

    task automatic wait_result();
        int lat = 0;
        while (out_valid !== 1'b1 && lat < MAXW) begin
            tick();
            lat++;
        end
        check("latency", 32'(lat), NCHUNK);
    endtask

    task automatic pop_exp(output logic [WIDTH:0] e);
        check("q_nonempty", 32'(exp_q.size() != 0), 1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    endtask

    task automatic retire();
        logic [WIDTH:0] e;
        pop_exp(e);
        check("result_valid", 32'(out_valid), 1);
        check("result_sum", 32'(sum), 32'(e));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("retire_out_valid", 32'(out_valid), 0);
        check("retire_in_ready", 32'(in_ready), 1);
        check("retire_busy", 32'(busy), 0);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
`ifdef SERIAL_ADD_SUB_EN
        sub_s     = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Idle after reset
        for (int i = 0; i < 3; i++) begin
            check("idle_in_ready", 32'(in_ready), 1);
            check("idle_out_valid", 32'(out_valid), 0);
            check("idle_busy", 32'(busy), 0);
            check("idle_sum", 32'(sum), 0);
            tick();
        end

        // Basic add
        start(16'h1234, 16'h4321, 1'b0);
        wait_result();
        check("sum_05555", 32'(sum), 32'h05555);
        retire();

        // Carry through every chunk
        start(16'hFFFF, 16'h0001, 1'b0);
        wait_result();
        check("sum_10000", 32'(sum), 32'h10000);
        retire();

        // Back-pressure and ignored in_valid while busy
        start(16'h00FF, 16'h0001, 1'b0);
        a        = 16'hDEAD;
        b        = 16'hBEEF;
        in_valid = 1'b1;
        wait_result();
        pop_exp(e_v);
        for (int i = 0; i < 5; i++) begin
            check("hold_out_valid", 32'(out_valid), 1);
            check("hold_sum", 32'(sum), 32'(e_v));
            check("hold_in_ready", 32'(in_ready), 0);
            tick();
        end
        check("hold_sum_00100", 32'(sum), 32'h00100);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("hold_retire_out_valid", 32'(out_valid), 0);
        check("hold_retire_in_ready", 32'(in_ready), 1);
        tick();
        check("hold_no_extra_busy", 32'(busy), 0);

        // Retire and new in_valid in the same DONE cycle
        start(16'h0003, 16'h0004, 1'b0);
        wait_result();
        pop_exp(e_v);
        check("combo_sum", 32'(sum), 32'(e_v));
        a         = 16'h0010;
        b         = 16'h0020;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("combo_out_valid", 32'(out_valid), 0);
        check("combo_in_ready", 32'(in_ready), 1);
        check("combo_busy", 32'(busy), 0);
        exp_q.push_back(model(16'h0010, 16'h0020, 1'b0));
        tick();
        in_valid = 1'b0;
        check("combo_accept_busy", 32'(busy), 1);
        wait_result();
        retire();

        // Reset during the second RUN cycle aborts the operation
        start(16'hAAAA, 16'h5555, 1'b0);
        void'(exp_q.pop_back());
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_in_ready", 32'(in_ready), 1);
        check("abort_busy", 32'(busy), 0);
        check("abort_out_valid", 32'(out_valid), 0);
        check("abort_sum", 32'(sum), 0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid !== 1'b0) seen = 1'b1;
            tick();
        end
        check("abort_no_valid", 32'(seen), 0);
        start(16'h0001, 16'h0002, 1'b0);
        wait_result();
        check("sum_00003", 32'(sum), 32'h00003);
        retire();

        // Random operands with random back-pressure
        for (int i = 0; i < 6; i++) begin
            int hold;
            hold = $urandom_range(0, 2);
            start(WIDTH'($urandom_range(0, 65535)), WIDTH'($urandom_range(0, 65535)), 1'b0);
            wait_result();
            for (int j = 0; j < hold; j++) tick();
            retire();
        end

`ifdef SERIAL_ADD_SUB_EN
        start(16'h0005, 16'h0007, 1'b1);
        wait_result();
        check("sub_borrow", 32'(sum), 32'h0FFFE);
        retire();
        start(16'h0007, 16'h0005, 1'b1);
        wait_result();
        check("sub_no_borrow", 32'(sum), 32'h10002);
        retire();
        start(16'h1234, 16'h1234, 1'b1);
        wait_result();
        retire();
        sub_s = 1'b0;
`endif

        check("queue_empty", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Multi-cycle controller that adds two WIDTH-bit operands using one CHUNK-bit ripple adder slice built from full adders. It sequences the slice over WIDTH/CHUNK cycles and carries between chunks through a registered carry flip-flop. Valid/ready handshakes sit on both the operand side and the result side. It lets one narrow adder serve wide arithmetic in the datapath.

Parameters:
WIDTH, 16, operand width in bits; must be a nonzero multiple of CHUNK.
CHUNK, 4, bits added per cycle (width of the adder slice).

Ports:
clk  input  1  single clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  operands a/b present.
in_ready  output  1  controller can accept operands.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
out_valid  output  1  sum holds a completed result.
out_ready  input  1  consumer accepts the result.
sum  output  WIDTH+1  result; bit WIDTH is the final carry-out.
busy  output  1  high in RUN or DONE.

Behaviour:
- Reset is synchronous and active-high. On a clk edge with reset=1:
  - state=IDLE, chunk index=0, carry=0, operand registers=0, sum=0, out_valid=0.
  - in_ready=1 and busy=0 from the first cycle after reset.
- NCHUNK = WIDTH/CHUNK. The index counter is ceil(log2(NCHUNK+1)) bits wide.
- The FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, busy=0, out_valid=0.
  - A handshake (in_valid && in_ready) latches a and b, clears carry, sets index=0, and moves to RUN.
  - Without in_valid, the FSM stays in IDLE.
- RUN:
  - in_ready=0, busy=1.
  - Each cycle adds a_reg[index*CHUNK +: CHUNK] + b_reg[same slice] + carry through the slice.
  - The chunk sum is written to sum[index*CHUNK +: CHUNK]. carry takes the slice carry-out. index increments.
  - At index == NCHUNK-1, the slice carry-out is also written to sum[WIDTH] and the FSM moves to DONE.
- DONE:
  - out_valid=1, busy=1, in_ready=0.
  - sum is held stable while out_ready=0.
  - On out_ready=1, the FSM moves to IDLE and out_valid falls on the next cycle.
- Latency: out_valid rises exactly NCHUNK clk edges after the input handshake edge (4 for the defaults). Throughput is one result per NCHUNK+2 cycles.
- Boundary conditions:
  - in_valid while busy: ignored. in_ready=0 and the operands are not sampled.
  - out_ready while not in DONE: ignored.
  - out_ready and in_valid high in the same DONE cycle: the result retires. The new operands are accepted no earlier than the following IDLE cycle.
  - Reset mid-RUN or mid-DONE: the operation aborts. out_valid does not assert for the aborted operation and sum=0.
  - sum is not guaranteed meaningful outside DONE. Consumers sample it only when out_valid=1.
  - Carry-out wraps into sum[WIDTH] only. There is no overflow flag; the sum is unsigned.
  - NCHUNK==1 (CHUNK==WIDTH) is legal: RUN lasts exactly one cycle.
  - Operand registers change only on an input handshake or reset.

Optional Feature:
- Macro: SERIAL_ADD_SUB_EN.
- When defined:
  - Adds port sub (input, 1), sampled with a and b on the input handshake.
  - If sub=1, the latched b is bitwise inverted and the initial carry=1, so sum = a + ~b + 1.
  - sum[WIDTH]=1 means no borrow (a>=b). sum[WIDTH]=0 means borrow.
  - Latency is unchanged.
- When undefined:
  - The sub port does not exist and the initial carry is always 0.

Test Plan:
- Reset, then idle 3 cycles: in_ready=1, out_valid=0, busy=0, sum=0 throughout.
- a=0x1234, b=0x4321, handshake at edge T: out_valid=1 starting at T+4 with sum=0x05555, and busy=1 from T+1.
- a=0xFFFF, b=0x0001: sum=0x10000, confirming carry propagates across all 4 chunks.
- a=0x00FF, b=0x0001 with out_ready held 0 for 5 cycles in DONE: sum=0x00100 stable and out_valid=1 throughout. in_valid pulsed during RUN/DONE is ignored. After out_ready=1, in_ready=1 on the next cycle.
- Start a=0xAAAA, b=0x5555; assert reset during the 2nd RUN cycle: the next cycle shows IDLE, sum=0, and out_valid never asserts. A subsequent a=0x0001, b=0x0002 yields 0x00003.
- With SERIAL_ADD_SUB_EN, sub=1:
  - a=0x0005, b=0x0007 gives sum=0x0FFFE (borrow).
  - a=0x0007, b=0x0005 gives sum=0x10002 (no borrow).
